// File: rtl/qsys_timer_bridge_pkg.sv
// ============================================================================
// Module   : qsys_timer_bridge_pkg
// Brief    : Shared types and constants for the 32-to-16 bit timer bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package qsys_timer_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_LO   = 3'd1,
        WR_HI   = 3'd2,
        RD_LO   = 3'd3,
        RD_HI   = 3'd4,
        RD_DONE = 3'd5
    } state_t;

    // Half-word offset appended below the word address
    localparam logic LO = 1'b0;
    localparam logic HI = 1'b1;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 3;

endpackage

`default_nettype wire

// File: rtl/qsys_timer_bridge_if.sv
// ============================================================================
// Module   : qsys_timer_bridge_if
// Brief    : Upstream 32-bit and downstream 16-bit timer bus signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface qsys_timer_bridge_if;

    logic [1:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [3:0]  s_byteenable;
    logic        s_waitrequest;
    logic [31:0] s_readdata;
    logic        s_readdatavalid;
    logic        s_irq;

    logic [2:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [15:0] m_writedata;
    logic [15:0] m_readdata;
    logic        m_irq;

    // Bridge side
    modport slave (
        input  s_address, s_read, s_write, s_writedata, s_byteenable,
        input  m_readdata, m_irq,
        output s_waitrequest, s_readdata, s_readdatavalid, s_irq,
        output m_address, m_chipselect, m_write_n, m_writedata
    );

    // Environment side: upstream master plus timer slave
    modport master (
        output s_address, s_read, s_write, s_writedata, s_byteenable,
        output m_readdata, m_irq,
        input  s_waitrequest, s_readdata, s_readdatavalid, s_irq,
        input  m_address, m_chipselect, m_write_n, m_writedata
    );

endinterface

`default_nettype wire

// File: rtl/qsys_timer_bridge.sv
// ============================================================================
// Module   : qsys_timer_bridge
// Brief    : Splits 32-bit accesses into two 16-bit timer accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qsys_timer_bridge
    import qsys_timer_bridge_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    qsys_timer_bridge_if.slave bus
);

    // Out-of-range latencies are clamped so the 2-bit counter stays valid
    localparam int c_lat_int = (READ_LATENCY < READ_LATENCY_MIN) ? READ_LATENCY_MIN :
                               (READ_LATENCY > READ_LATENCY_MAX) ? READ_LATENCY_MAX :
                               READ_LATENCY;
    localparam logic [1:0] c_lat = 2'(c_lat_int);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [1:0]  r_cnt;
    logic [15:0] r_rd_lo;
    logic [31:0] r_rdata;
    logic        w_accept;
    logic        w_cnt_load;

    assign w_accept   = (r_state == IDLE) && (bus.s_read || bus.s_write);
    assign w_cnt_load = ((w_next == RD_LO) && (r_state != RD_LO)) ||
                        ((w_next == RD_HI) && (r_state != RD_HI));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Command latches, wait counter and read capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_cnt   <= '0;
            r_rd_lo <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.s_address;
                r_wdata <= bus.s_writedata;
                r_be    <= bus.s_byteenable;
            end
            if (w_cnt_load) begin
                r_cnt <= c_lat;
            end else if (((r_state == RD_LO) || (r_state == RD_HI)) && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if ((r_state == RD_LO) && (r_cnt == 2'd0)) begin
                r_rd_lo <= bus.m_readdata;
            end
            // Upper half and held lower half land together so s_readdata only moves at RD_DONE
            if ((r_state == RD_HI) && (r_cnt == 2'd0)) begin
                r_rdata <= {bus.m_readdata, r_rd_lo};
            end
        end
    end

    // Next-state logic; a write wins over a simultaneous read
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.s_write) begin
                    if (bus.s_byteenable[1:0] != 2'b00) begin
                        w_next = WR_LO;
                    end else if (bus.s_byteenable[3:2] != 2'b00) begin
                        w_next = WR_HI;
                    end else begin
                        w_next = IDLE;
                    end
                end else if (bus.s_read) begin
                    w_next = RD_LO;
                end
            end
            WR_LO:   w_next = (r_be[3:2] != 2'b00) ? WR_HI : IDLE;
            WR_HI:   w_next = IDLE;
            RD_LO:   w_next = (r_cnt == 2'd0) ? RD_HI : RD_LO;
            RD_HI:   w_next = (r_cnt == 2'd0) ? RD_DONE : RD_HI;
            RD_DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        bus.s_waitrequest   = 1'b1;
        bus.s_readdatavalid = 1'b0;
        bus.m_chipselect    = 1'b0;
        bus.m_write_n       = 1'b1;
        bus.m_address       = 3'd0;
        bus.m_writedata     = 16'd0;
        case (r_state)
            IDLE: begin
                bus.s_waitrequest = 1'b0;
            end
            WR_LO: begin
                bus.m_chipselect = 1'b1;
                bus.m_write_n    = 1'b0;
                bus.m_address    = {r_addr, LO};
                bus.m_writedata  = r_wdata[15:0];
            end
            WR_HI: begin
                bus.m_chipselect = 1'b1;
                bus.m_write_n    = 1'b0;
                bus.m_address    = {r_addr, HI};
                bus.m_writedata  = r_wdata[31:16];
            end
            RD_LO: begin
                bus.m_chipselect = 1'b1;
                bus.m_address    = {r_addr, LO};
            end
            RD_HI: begin
                bus.m_chipselect = 1'b1;
                bus.m_address    = {r_addr, HI};
            end
            RD_DONE: begin
                bus.s_readdatavalid = 1'b1;
            end
            default: begin
                bus.s_waitrequest = 1'b1;
            end
        endcase
    end

    assign bus.s_readdata = r_rdata;
    assign bus.s_irq      = bus.m_irq;

endmodule

`default_nettype wire
